// File: rtl/qos_egress_arbiter.sv
// QoS egress arbiter: drains four class FIFOs round-robin into one egress
// stream, honours downstream almost-full, and keeps per-class word counters.
module qos_egress_arbiter #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active_in,
    input  logic              fifo_empty0,
    input  logic              fifo_empty1,
    input  logic              fifo_empty2,
    input  logic              fifo_empty3,
    input  logic [DATA_W-1:0] fifo_dataout0,
    input  logic [DATA_W-1:0] fifo_dataout1,
    input  logic [DATA_W-1:0] fifo_dataout2,
    input  logic [DATA_W-1:0] fifo_dataout3,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    input  logic              out_almost_full,
    output logic [DATA_W-1:0] data_out,
    output logic              push_out,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic              valid,
    output logic [CNT_W-1:0]  data
);
    localparam int unsigned NUM_CLS = 4;
    localparam int unsigned CLS_W   = 2;

    logic [NUM_CLS-1:0] empty;
    logic [NUM_CLS-1:0] pop_q;
    logic [CLS_W-1:0]   ptr_q;
    logic [CLS_W-1:0]   grant;
    logic               found;
    logic               eligible;
    logic [CLS_W-1:0]   pop_cls;
    logic               tag_vld_q;
    logic [CLS_W-1:0]   tag_q;
    logic [DATA_W-1:0]  tag_data;
    logic [CLS_W-1:0]   push_cls_q;
    logic [CNT_W-1:0]   cnt_q [NUM_CLS];
    logic [CNT_W-1:0]   total_q;
    logic [CNT_W-1:0]   rd_sel;

    assign empty = {fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0};
    assign pop0  = pop_q[0];
    assign pop1  = pop_q[1];
    assign pop2  = pop_q[2];
    assign pop3  = pop_q[3];

    // First non-empty class scanning upward from the pointer, wrapping 3->0
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_CLS); i++) begin
            if (!found && !empty[ptr_q + CLS_W'(i)]) begin
                grant = ptr_q + CLS_W'(i);
                found = 1'b1;
            end
        end
    end

    assign eligible = active_in & ~out_almost_full & found;

    // Registered pop strobe and round-robin pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_q <= '0;
            ptr_q <= '0;
        end else begin
            pop_q <= '0;
            if (eligible) begin
                pop_q <= NUM_CLS'(1) << grant;
                ptr_q <= grant + CLS_W'(1);
            end
        end
    end

    // Encode the class being popped this cycle
    always_comb begin
        pop_cls = '0;
        for (int i = 0; i < int'(NUM_CLS); i++) begin
            if (pop_q[i]) begin
                pop_cls = CLS_W'(i);
            end
        end
    end

    // One-stage tag pipe: remembers which FIFO will present data next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_q <= 1'b0;
            tag_q     <= '0;
        end else begin
            tag_vld_q <= |pop_q;
            tag_q     <= pop_cls;
        end
    end

    // Select read data of the tagged class
    always_comb begin
        tag_data = fifo_dataout0;
        case (tag_q)
            2'd0:    tag_data = fifo_dataout0;
            2'd1:    tag_data = fifo_dataout1;
            2'd2:    tag_data = fifo_dataout2;
            default: tag_data = fifo_dataout3;
        endcase
    end

    // Egress register: word and push strobe, class kept for counting
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            push_out   <= 1'b0;
            push_cls_q <= '0;
        end else begin
            push_out <= tag_vld_q;
            if (tag_vld_q) begin
                data_out   <= tag_data;
                push_cls_q <= tag_q;
            end
        end
    end

    // Per-class and total forwarded-word counters, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CLS); i++) begin
                cnt_q[i] <= '0;
            end
            total_q <= '0;
        end else if (push_out) begin
            cnt_q[push_cls_q] <= cnt_q[push_cls_q] + CNT_W'(1);
            total_q           <= total_q + CNT_W'(1);
        end
    end

    // Counter readout selection
    always_comb begin
        rd_sel = '0;
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: rd_sel = cnt_q[idx[CLS_W-1:0]];
            3'd4:                   rd_sel = total_q;
            default:                rd_sel = '0;
        endcase
    end

    // Registered readout; sees counters before any same-cycle increment
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= req;
            data  <= req ? rd_sel : '0;
        end
    end

endmodule

// File: tb/tb_qos_egress_arbiter.sv
// Directed bench for qos_egress_arbiter with behavioural class FIFOs.
module tb_qos_egress_arbiter;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              active_in;
    logic              fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3;
    logic [DATA_W-1:0] fifo_dataout0, fifo_dataout1, fifo_dataout2, fifo_dataout3;
    logic              pop0, pop1, pop2, pop3;
    logic              out_almost_full;
    logic [DATA_W-1:0] data_out;
    logic              push_out;
    logic              req;
    logic [2:0]        idx;
    logic              valid;
    logic [CNT_W-1:0]  data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qos_egress_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .active_in(active_in),
        .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
        .fifo_empty2(fifo_empty2), .fifo_empty3(fifo_empty3),
        .fifo_dataout0(fifo_dataout0), .fifo_dataout1(fifo_dataout1),
        .fifo_dataout2(fifo_dataout2), .fifo_dataout3(fifo_dataout3),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .out_almost_full(out_almost_full), .data_out(data_out), .push_out(push_out),
        .req(req), .idx(idx), .valid(valid), .data(data)
    );

    // Class FIFO models: pop consumed at the edge ending the pop cycle,
    // data valid the following cycle, empty reflects a pop in progress.
    logic [DATA_W-1:0] mem [4][512];
    int                wr_ptr [4] = '{0, 0, 0, 0};
    int                rd_ptr [4] = '{0, 0, 0, 0};
    logic [DATA_W-1:0] dout [4];
    logic [3:0]        pop_v;
    logic [3:0]        empty_v;

    assign pop_v = {pop3, pop2, pop1, pop0};
    assign {fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0} = empty_v;
    assign fifo_dataout0 = dout[0];
    assign fifo_dataout1 = dout[1];
    assign fifo_dataout2 = dout[2];
    assign fifo_dataout3 = dout[3];

    always_comb begin
        empty_v = '1;
        for (int k = 0; k < 4; k++) begin
            empty_v[k] = (wr_ptr[k] == rd_ptr[k]) ||
                         (((wr_ptr[k] - rd_ptr[k]) == 1) && pop_v[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (pop_v[k] && (wr_ptr[k] != rd_ptr[k])) begin
                dout[k]   <= mem[k][rd_ptr[k] % 512];
                rd_ptr[k] <= rd_ptr[k] + 1;
            end
        end
    end

    // Event log of pushes and pops; counts pops of a truly empty FIFO or multi-pops
    int                n_push = 0;
    int                n_pop  = 0;
    int                n_bad  = 0;
    int                push_cyc [1024];
    logic [DATA_W-1:0] push_dat [1024];
    int                pop_cyc  [1024];
    int                pop_cls  [1024];

    always @(negedge clk) begin
        if (push_out) begin
            if (n_push < 1024) begin
                push_cyc[n_push] = cyc;
                push_dat[n_push] = data_out;
            end
            n_push++;
        end
        for (int k = 0; k < 4; k++) begin
            if (pop_v[k]) begin
                if (n_pop < 1024) begin
                    pop_cyc[n_pop] = cyc;
                    pop_cls[n_pop] = k;
                end
                n_pop++;
                if (wr_ptr[k] == rd_ptr[k]) n_bad++;
            end
        end
        if ($countones(pop_v) > 1) n_bad++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [DATA_W-1:0] w);
        mem[k][wr_ptr[k] % 512] = w;
        wr_ptr[k] = wr_ptr[k] + 1;
    endtask

    task automatic read_cnt(input logic [2:0] i, output logic v, output logic [CNT_W-1:0] d);
        req = 1'b1;
        idx = i;
        step(1);
        v   = valid;
        d   = data;
        req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; active_in = 1'b0; out_almost_full = 1'b0; req = 1'b0; idx = '0;
        step(3);
        vectors++; if (pop_v !== 4'b0) begin miscompares++; $display("FAIL reset_pop: got %b want 0000", pop_v); end
        vectors++; if (push_out !== 1'b0) begin miscompares++; $display("FAIL reset_push: got %b want 0", push_out); end
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL reset_data_out: got %h want 000", data_out); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
        vectors++; if (data !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 00", data); end
        reset = 1'b0; active_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1);
            vectors++; if (pop_v !== 4'b0) begin miscompares++; $display("FAIL idle_pop c%0d: got %b want 0000", c, pop_v); end
            vectors++; if (push_out !== 1'b0) begin miscompares++; $display("FAIL idle_push c%0d: got %b want 0", c, push_out); end
            vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid c%0d: got %b want 0", c, valid); end
            vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL idle_data_out c%0d: got %h want 000", c, data_out); end
        end
    endtask

    task automatic test_round_robin;
        int d, pb, qb;
        int exp_cls [5] = '{0, 1, 2, 3, 0};
        logic [DATA_W-1:0] exp_dat [5] = '{12'h0FF, 12'h55A, 12'hA5A, 12'hF5A, 12'h404};
        load(0, 12'h0FF); load(0, 12'h404); load(1, 12'h55A); load(2, 12'hA5A); load(3, 12'hF5A);
        d = cyc; pb = n_push; qb = n_pop;
        step(10);
        vectors++; if (n_pop - qb !== 5) begin miscompares++; $display("FAIL rr_pop_count: got %0d want 5", n_pop - qb); end
        vectors++; if (n_push - pb !== 5) begin miscompares++; $display("FAIL rr_push_count: got %0d want 5", n_push - pb); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (pop_cls[qb+i] !== exp_cls[i] || pop_cyc[qb+i] !== d + 1 + i) begin
                miscompares++; $display("FAIL rr_pop%0d: got class %0d at +%0d want class %0d at +%0d",
                    i, pop_cls[qb+i], pop_cyc[qb+i] - d, exp_cls[i], 1 + i); end
            vectors++; if (push_dat[pb+i] !== exp_dat[i] || push_cyc[pb+i] !== d + 3 + i) begin
                miscompares++; $display("FAIL rr_push%0d: got %h at +%0d want %h at +%0d",
                    i, push_dat[pb+i], push_cyc[pb+i] - d, exp_dat[i], 3 + i); end
        end
    endtask

    task automatic test_readout;
        logic [2:0]       sel [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        logic [CNT_W-1:0] exp [7] = '{8'd2, 8'd1, 8'd1, 8'd1, 8'd5, 8'd0, 8'd0};
        req = 1'b1; idx = sel[0];
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (i < 6) idx = sel[i+1];
            vectors++; if (valid !== 1'b1 || data !== exp[i]) begin
                miscompares++; $display("FAIL readout idx%0d: got valid=%b data=%0d want valid=1 data=%0d",
                    sel[i], valid, data, exp[i]); end
        end
        req = 1'b0;
        step(1);
        vectors++; if (valid !== 1'b0 || data !== '0) begin
            miscompares++; $display("FAIL readout_idle: got valid=%b data=%0d want valid=0 data=0", valid, data); end
    endtask

    task automatic test_single_class;
        int d, pb, qb, bb;
        logic [DATA_W-1:0] w [4] = '{12'h111, 12'h222, 12'h333, 12'h444};
        for (int i = 0; i < 4; i++) load(2, w[i]);
        d = cyc; pb = n_push; qb = n_pop; bb = n_bad;
        step(10);
        vectors++; if (n_pop - qb !== 4) begin miscompares++; $display("FAIL p2_pop_count: got %0d want 4", n_pop - qb); end
        vectors++; if (n_bad !== bb) begin miscompares++; $display("FAIL p2_empty_pop: got %0d want 0", n_bad - bb); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (pop_cls[qb+i] !== 2 || pop_cyc[qb+i] !== d + 1 + i) begin
                miscompares++; $display("FAIL p2_pop%0d: got class %0d at +%0d want class 2 at +%0d",
                    i, pop_cls[qb+i], pop_cyc[qb+i] - d, 1 + i); end
            vectors++; if (push_dat[pb+i] !== w[i] || push_cyc[pb+i] !== d + 3 + i) begin
                miscompares++; $display("FAIL p2_push%0d: got %h at +%0d want %h at +%0d",
                    i, push_dat[pb+i], push_cyc[pb+i] - d, w[i], 3 + i); end
        end
    endtask

    task automatic test_backpressure;
        int d, pb, qb, held;
        int exp_cls [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
        int exp_off [8] = '{1, 2, 9, 10, 11, 12, 13, 14};
        logic [DATA_W-1:0] exp_dat [8] = '{12'h401, 12'h101, 12'h201, 12'h301,
                                          12'h402, 12'h102, 12'h202, 12'h302};
        for (int k = 0; k < 4; k++) begin
            load(k, DATA_W'(((k + 1) << 8) | 1));
            load(k, DATA_W'(((k + 1) << 8) | 2));
        end
        d = cyc; pb = n_push; qb = n_pop;
        step(2);
        out_almost_full = 1'b1;
        step(6);
        held = n_push - pb;
        vectors++; if (held !== 2) begin miscompares++; $display("FAIL bp_held_pushes: got %0d want 2", held); end
        vectors++; if (n_pop - qb !== 2) begin miscompares++; $display("FAIL bp_held_pops: got %0d want 2", n_pop - qb); end
        out_almost_full = 1'b0;
        step(10);
        vectors++; if (n_pop - qb !== 8) begin miscompares++; $display("FAIL bp_pop_count: got %0d want 8", n_pop - qb); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (pop_cls[qb+i] !== exp_cls[i] || pop_cyc[qb+i] !== d + exp_off[i]) begin
                miscompares++; $display("FAIL bp_pop%0d: got class %0d at +%0d want class %0d at +%0d",
                    i, pop_cls[qb+i], pop_cyc[qb+i] - d, exp_cls[i], exp_off[i]); end
            vectors++; if (push_dat[pb+i] !== exp_dat[i] || push_cyc[pb+i] !== d + exp_off[i] + 2) begin
                miscompares++; $display("FAIL bp_push%0d: got %h at +%0d want %h at +%0d",
                    i, push_dat[pb+i], push_cyc[pb+i] - d, exp_dat[i], exp_off[i] + 2); end
        end
    endtask

    task automatic test_wrap;
        int d, pb, qb, bb, bad_seq;
        logic v;
        logic [CNT_W-1:0] r;
        logic [2:0]       sel [5] = '{3'd1, 3'd4, 3'd0, 3'd2, 3'd3};
        logic [CNT_W-1:0] exp [5] = '{8'd0, 8'd14, 8'd4, 8'd7, 8'd3};
        for (int i = 0; i < 253; i++) load(1, DATA_W'(12'h800 + i));
        d = cyc; pb = n_push; qb = n_pop; bb = n_bad;
        step(262);
        vectors++; if (n_push - pb !== 253) begin miscompares++; $display("FAIL wrap_push_count: got %0d want 253", n_push - pb); end
        vectors++; if (n_bad !== bb) begin miscompares++; $display("FAIL wrap_empty_pop: got %0d want 0", n_bad - bb); end
        bad_seq = 0;
        for (int i = 0; i < 253; i++) begin
            if (push_dat[pb+i] !== DATA_W'(12'h800 + i) || push_cyc[pb+i] !== d + 3 + i) bad_seq++;
        end
        vectors++; if (bad_seq !== 0) begin miscompares++; $display("FAIL wrap_stream: got %0d bad words want 0", bad_seq); end
        for (int i = 0; i < 5; i++) begin
            read_cnt(sel[i], v, r);
            vectors++; if (v !== 1'b1 || r !== exp[i]) begin
                miscompares++; $display("FAIL wrap_cnt idx%0d: got valid=%b data=%0d want valid=1 data=%0d",
                    sel[i], v, r, exp[i]); end
        end
    endtask

    task automatic test_reset_midflight;
        int d, pb, qb;
        logic v;
        logic [CNT_W-1:0] r;
        load(1, 12'h611); load(1, 12'h612); load(2, 12'h621); load(2, 12'h622);
        d = cyc; pb = n_push;
        step(2);
        reset = 1'b1; active_in = 1'b0;
        step(1);
        for (int k = 0; k < 4; k++) wr_ptr[k] = rd_ptr[k];
        vectors++; if (push_out !== 1'b0) begin miscompares++; $display("FAIL mid_reset_push: got %b want 0", push_out); end
        vectors++; if (pop_v !== 4'b0) begin miscompares++; $display("FAIL mid_reset_pop: got %b want 0000", pop_v); end
        step(1);
        reset = 1'b0;
        step(4);
        vectors++; if (n_push !== pb) begin miscompares++; $display("FAIL mid_reset_discard: got %0d pushes want 0", n_push - pb); end
        for (int i = 0; i < 5; i++) begin
            read_cnt(3'(i), v, r);
            vectors++; if (v !== 1'b1 || r !== '0) begin
                miscompares++; $display("FAIL mid_reset_cnt idx%0d: got valid=%b data=%0d want valid=1 data=0", i, v, r); end
        end
        load(2, 12'h631); load(0, 12'h632);
        active_in = 1'b1;
        d = cyc; pb = n_push; qb = n_pop;
        step(8);
        vectors++; if (pop_cls[qb] !== 0 || pop_cyc[qb] !== d + 1) begin
            miscompares++; $display("FAIL mid_reset_ptr: got class %0d at +%0d want class 0 at +1",
                pop_cls[qb], pop_cyc[qb] - d); end
        vectors++; if (push_dat[pb] !== 12'h632 || push_dat[pb+1] !== 12'h631 || n_push - pb !== 2) begin
            miscompares++; $display("FAIL mid_reset_restart: got %h,%h (%0d pushes) want 632,631 (2 pushes)",
                push_dat[pb], push_dat[pb+1], n_push - pb); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_readout();
        test_single_class();
        test_backpressure();
        test_wrap();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qos_egress_arbiter.md
Name: qos_egress_arbiter

Overview:
- Read-side counterpart of the QoS PCIe ingress path. It drains the four per-class output FIFOs (P0–P3) with round-robin arbitration and merges their 12-bit words into a single egress stream.
- It honours downstream almost-full backpressure.
- It keeps per-class forwarded-word counters, readable through a req/idx/valid/data port with the same shape as the ingress counter block.

Parameters:
- DATA_W, 12, word width of the class FIFOs and of the egress stream
- CNT_W, 8, width of each word counter and of the readout data

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- active_in  in  1  enable from the QoS state machine; arbitration runs only while 1
- fifo_empty0..fifo_empty3  in  1 each  class FIFO empty flags; updated at the same edge that consumes a pop
- fifo_dataout0..fifo_dataout3  in  DATA_W each  class FIFO read data; valid the cycle after the pop
- pop0..pop3  out  1 each  class FIFO pop strobes; at most one high per cycle
- out_almost_full  in  1  downstream FIFO almost-full flag
- data_out  out  DATA_W  egress word
- push_out  out  1  egress push strobe
- req  in  1  counter read request
- idx  in  3  counter select
- valid  out  1  counter readout valid
- data  out  CNT_W  counter readout value

Behaviour:
- Reset (reset=1 at a rising edge):
  - All outputs go to 0: pop*, push_out, data_out, valid, data.
  - The round-robin pointer goes to class 0.
  - All counters and the in-flight pipeline clear.
  - A reset mid-transfer discards any in-flight word; push_out=0 on the next cycle.
- Eligibility in cycle N: active_in=1, out_almost_full=0, and at least one fifo_emptyK=0.
- Grant:
  - The first non-empty class, scanning from the pointer upward and wrapping 3→0.
  - The pop for the granted class is registered and seen high during cycle N+1.
  - The pointer becomes (grant+1) mod 4.
  - With no eligible class, no pop is issued and the pointer holds.
- Pop data path:
  - Pops are registered outputs, so eligibility is evaluated on registered empty flags.
  - The same class may be popped on consecutive cycles if it is the only non-empty class.
  - The block must never pop a FIFO whose fifo_empty is 1 in the deciding cycle.
- Capture and latency:
  - Cycle N+1 (pop high): the block records the granted class in a one-stage tag pipe.
  - Cycle N+2: fifo_dataoutK is valid; it is registered into data_out with push_out=1, visible in N+3.
  - Total latency from the eligibility decision to push_out is 3 cycles.
  - Throughput is one word per cycle.
- Backpressure:
  - out_almost_full=1 stops new pops in the same decision cycle.
  - Up to 2 words already in flight are still pushed. The downstream almost-full threshold must leave at least 2 free entries.
- active_in falling: stops new pops; in-flight words complete.
- Counters:
  - cnt[K] increments when push_out fires for class K.
  - total increments on every push.
  - All counters are CNT_W bits, wrap 255→0, and clear only on reset.
- Readout:
  - req=1 in cycle N gives valid=1 in N+1 with data as follows:
    - idx 0–3: cnt[idx]
    - idx 4: total
    - idx 5–7: 0
  - req=0 gives valid=0 and data=0.
  - A read in the same cycle as an increment returns the pre-increment value.
  - Back-to-back reqs return back-to-back values.

Test Plan:
1. Reset, then all FIFOs empty with active_in=1 for 10 cycles → pop*=0, push_out=0, valid=0, data_out=0.
2. P0 holds 0x0FF and 0x404; P1 holds 0x55A; P2 holds 0xA5A; P3 holds 0xF5A; active_in=1 → pops in order P0,P1,P2,P3,P0. push_out sequence is 0x0FF,0x55A,0xA5A,0xF5A,0x404 on consecutive cycles, first push 3 cycles after the first decision.
3. Only P2 non-empty with 4 words → pop2 high for 4 consecutive cycles; the words emerge in FIFO order; pop2 never high with fifo_empty2=1.
4. Raise out_almost_full mid-stream → no new pop from the next decision; at most 2 further pushes. Drop the flag → arbitration resumes at the pointer where it stopped.
5. After scenario 2, req=1 with idx 0,1,2,3,4,5 on consecutive cycles → data = 2,1,1,1,5,0 with valid=1 each cycle. Also force 256 P1 pushes → cnt[1] wraps to 0.
6. Assert reset while 2 words are in flight → no push on the following cycles, all counters 0, and the pointer restarts at P0.
